// File: rtl/neuron_accum_thresh.sv
// Accumulates signed adder-tree partial sums for one neuron and thresholds the total into an activation bit.
// Define ACC_SAT_EN to saturate each accumulator add instead of wrapping.
module neuron_accum_thresh #(
  parameter int WIDTH_IN  = 8,
  parameter int ACC_W     = WIDTH_IN + 16,
  parameter int MAX_BEATS = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [WIDTH_IN+10:0] in_sum,
  input  logic                       in_last,
  input  logic signed [ACC_W-1:0]    threshold,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_bit,
  output logic signed [ACC_W-1:0]    out_acc,
  output logic                       err_ovf
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] thr_q, thr_d;
  logic signed [ACC_W-1:0] out_acc_q, out_acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    out_bit_q, out_bit_d;
  logic                    err_q, err_d;
  logic                    beat;

  function automatic logic signed [ACC_W-1:0] sext_in(input logic signed [WIDTH_IN+10:0] s);
    return ACC_W'(s);
  endfunction

  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W-1:0] s;
    s = a + b;
`ifdef ACC_SAT_EN
    // Overflow only when both operands share a sign the result lacks.
    if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]))
      s = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
    return s;
  endfunction

  assign in_ready  = (state_q == DONE) ? out_ready : 1'b1;
  assign beat      = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out_bit   = out_bit_q;
  assign out_acc   = out_acc_q;
  assign err_ovf   = err_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    thr_d     = thr_q;
    cnt_d     = cnt_q;
    out_acc_d = out_acc_q;
    out_bit_d = out_bit_q;
    err_d     = err_q;

    if ((state_q == DONE) && out_ready && !in_valid)
      state_d = IDLE;

    if (beat) begin
      if (state_q == ACC) begin
        acc_d = acc_add(acc_q, sext_in(in_sum));
        // Count saturates at MAX_BEATS; any further beat is an overrun.
        if (cnt_q == CNT_W'(MAX_BEATS))
          err_d = 1'b1;
        else
          cnt_d = cnt_q + 1'b1;
      end else begin
        acc_d = sext_in(in_sum);
        thr_d = threshold;
        cnt_d = CNT_W'(1);
      end

      if (in_last) begin
        state_d   = DONE;
        out_acc_d = acc_d;
        out_bit_d = (acc_d >= thr_d);
      end else begin
        state_d = ACC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      thr_q     <= '0;
      cnt_q     <= '0;
      out_acc_q <= '0;
      out_bit_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      thr_q     <= thr_d;
      cnt_q     <= cnt_d;
      out_acc_q <= out_acc_d;
      out_bit_q <= out_bit_d;
      err_q     <= err_d;
    end
  end

endmodule
